// File: rtl/hexdisplay_bank.sv
// Multi-digit seven-segment driver: captures a packed hex value on load and
// drives registered active-low segments. Blinking is compiled in with HEXDISPLAY_BLINK_EN.
module hexdisplay_bank #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      lz_blank,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [7*NUM_DIGITS-1:0]   HEX,
    output logic                      updated
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    logic [4*NUM_DIGITS-1:0] r_value;
    logic                    r_lz_blank;
    logic                    r_v1;
    logic                    r_live;
    logic [7*NUM_DIGITS-1:0] r_hex;
    logic                    r_updated;

    logic [NUM_DIGITS-1:0]   w_blink_hide;
    logic [NUM_DIGITS-1:0]   w_lz_hide;
    logic [NUM_DIGITS:1]     w_zero_above;
    logic [7*NUM_DIGITS-1:0] w_hex_next;

    // Stage 1: capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_value    <= '0;
            r_lz_blank <= 1'b0;
            r_v1       <= 1'b0;
        end else begin
            r_v1 <= load;
            if (load) begin
                r_value    <= value;
                r_lz_blank <= lz_blank;
            end
        end
    end

`ifdef HEXDISPLAY_BLINK_EN
    localparam int              CNT_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0]      r_blink_cnt;
    logic                  r_blink_phase;
    logic [NUM_DIGITS-1:0] r_blink_mask;

    // A load restarts blinking in the visible phase, even on a wrap edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_blink_mask  <= '0;
        end else if (load) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_blink_mask  <= blink_mask;
        end else if (r_blink_cnt == CNT_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blink_hide = r_blink_phase ? r_blink_mask : '0;
`else
    logic w_unused_blink;
    assign w_unused_blink = ^blink_mask;
    assign w_blink_hide   = '0;
`endif

    // Leading-zero run is tracked from the top digit downwards.
    assign w_zero_above[NUM_DIGITS] = 1'b1;
    assign w_lz_hide[0]             = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi < NUM_DIGITS - 1) begin : g_mid
                assign w_zero_above[gi] = w_zero_above[gi+1] && (r_value[4*gi +: 4] == 4'h0);
            end else begin : g_top
                assign w_zero_above[gi] = (r_value[4*gi +: 4] == 4'h0);
            end
            assign w_lz_hide[gi] = r_lz_blank && w_zero_above[gi];
        end

        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [6:0] w_seg;
            assign w_seg = seg_decode(r_value[4*gi +: 4]);
            assign w_hex_next[7*gi +: 7] = (w_lz_hide[gi] || w_blink_hide[gi]) ? SEG_BLANK : w_seg;
        end
    endgenerate

    // Stage 2: HEX stays blank after reset until a load has reached this stage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hex     <= '1;
            r_updated <= 1'b0;
            r_live    <= 1'b0;
        end else begin
            r_updated <= r_v1;
            if (r_v1) begin
                r_live <= 1'b1;
            end
            if (r_v1 || r_live) begin
                r_hex <= w_hex_next;
            end
        end
    end

    assign HEX     = r_hex;
    assign updated = r_updated;

endmodule

// File: tb/tb_hexdisplay_bank.sv
// Directed bench for hexdisplay_bank (NUM_DIGITS=6, BLINK_DIV=4); loads push
// expected patterns to a scoreboard that is popped whenever updated pulses.
module tb_hexdisplay_bank;

    localparam int ND = 6;
    localparam int BD = 4;
`ifdef HEXDISPLAY_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif
    localparam logic [41:0] ALL_BLANK = '1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic [23:0]   value = '0;
    logic          lz_blank = 1'b0;
    logic [5:0]    blink_mask = '0;
    logic [41:0]   hex;
    logic          updated;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [41:0]   exp_q[$];
    logic [6:0]    seg_tab[16];

    hexdisplay_bank #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .value(value),
        .lz_blank(lz_blank), .blink_mask(blink_mask), .HEX(hex), .updated(updated)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    function automatic logic [41:0] model(input logic [23:0] v, input logic lz,
                                          input logic [5:0] mask, input logic ph);
        logic [41:0] r;
        logic        seen;
        logic        blank;
        logic [3:0]  d;
        r    = '0;
        seen = 1'b0;
        for (int i = ND - 1; i >= 0; i--) begin
            d = v[4*i +: 4];
            if (d != 4'h0) seen = 1'b1;
            blank = (lz && !seen && i != 0) || (BLINK_ON && ph && mask[i]);
            r[7*i +: 7] = blank ? 7'h7F : seg_tab[d];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (updated === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL sb_underflow: observed updated=1 expected no pending load");
            end
            if (exp_q.size() != 0) chk("sb_hex", hex, exp_q.pop_front());
        end
    endtask

    task automatic do_load(input logic [23:0] v, input logic lz, input logic [5:0] mask);
        value      = v;
        lz_blank   = lz;
        blink_mask = mask;
        load       = 1'b1;
        exp_q.push_back(model(v, lz, mask, 1'b0));
        step();
        load = 1'b0;
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        // Reset held with a load pending
        reset_n = 1'b0;
        load    = 1'b1;
        value   = 24'h123456;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hex", hex, ALL_BLANK);
            chk("rst_upd", 42'(updated), 42'd0);
        end
        reset_n = 1'b1;
        load    = 1'b0;
        step();
        chk("rel_hex", hex, ALL_BLANK);
        chk("rel_upd", 42'(updated), 42'd0);

        // Leading-zero blanking
        do_load(24'h0012AF, 1'b1, 6'b0);
        step();
        chk("lz_hex", hex, {7'h7F, 7'h7F, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});
        chk("lz_upd", 42'(updated), 42'd1);
        step();
        chk("lz_upd_once", 42'(updated), 42'd0);
        chk("lz_hold", hex, {7'h7F, 7'h7F, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});

        // All-zero value, with and without blanking
        do_load(24'h000000, 1'b1, 6'b0);
        step();
        chk("zero_lz", hex, {{5{7'h7F}}, 7'b1000000});
        do_load(24'h000000, 1'b0, 6'b0);
        step();
        chk("zero_nolz", hex, {6{7'b1000000}});

        // Back-to-back loads
        do_load(24'h111111, 1'b0, 6'b0);
        do_load(24'h222222, 1'b0, 6'b0);
        chk("b2b_first", hex, {6{7'b1111001}});
        chk("b2b_first_upd", 42'(updated), 42'd1);
        step();
        chk("b2b_second", hex, {6{7'b0100100}});
        chk("b2b_second_upd", 42'(updated), 42'd1);

        // Blink on digit 0, reloaded in the middle of the blank phase
        do_load(24'h888888, 1'b0, 6'b000001);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("blink_a", hex, model(24'h888888, 1'b0, 6'b000001, (((k - 1) / BD) % 2) == 1));
            chk("blink_a_upd", 42'(updated), 42'(k == 1));
        end
        load = 1'b1;
        exp_q.push_back(model(24'h888888, 1'b0, 6'b000001, 1'b0));
        step();
        load = 1'b0;
        chk("blink_reload_edge", hex, model(24'h888888, 1'b0, 6'b000001, 1'b1));
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("blink_b", hex, model(24'h888888, 1'b0, 6'b000001, (((k - 1) / BD) % 2) == 1));
            chk("blink_b_upd", 42'(updated), 42'(k == 1));
        end

        // Reset arriving while a load is in flight
        value    = 24'hFFFFFF;
        lz_blank = 1'b0;
        load     = 1'b1;
        step();
        load    = 1'b0;
        reset_n = 1'b0;
        step();
        chk("midrst_hex", hex, ALL_BLANK);
        chk("midrst_upd", 42'(updated), 42'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("midrst_after_hex", hex, ALL_BLANK);
            chk("midrst_after_upd", 42'(updated), 42'd0);
        end

        for (int k = 0; k < 4 && exp_q.size() != 0; k++) step();
        chk("sb_drain", 42'(exp_q.size()), 42'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
